sram_like_bridge: RTL and testbench

//   Sits between a core memory port (inst or data side) and the sram-like bus
//   (req/addr_ok/data_ok). Requests use the pipeline valid/allowin handshake;

---
 rtl/sram_like_bridge_pkg.sv | 34 +++
 rtl/sram_like_bridge_if.sv | 43 ++++
 rtl/sram_like_bridge_resp_fifo.sv | 74 +++++++
 rtl/sram_like_bridge.sv | 146 ++++++++++++++
 tb/tb_sram_like_bridge.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_like_bridge_pkg.sv
// Shared definitions for the sram-like bridge: bus widths, FSM encodings,
// transfer-size codes, the latched request payload and the strobe->size map.
package sram_like_bridge_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned SIZE_W = 2;

    // FSM encodings kept as plain constants for legacy tooling
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

    // Request fields held on the bus from accept until addr_ok
    typedef struct packed {
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    // Full word or read -> word; aligned pairs -> half; single lane -> byte
    function automatic logic [SIZE_W-1:0] wstrb_to_size(input logic [STRB_W-1:0] wstrb);
        case (wstrb)
            4'b0011, 4'b1100:                   return SIZE_HALF;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return SIZE_BYTE;
            default:                            return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/sram_like_bridge_if.sv
// Core-port + sram-like bus signal bundle for one bridge instance.
//   master : the bridge (accepts core requests, drives the bus request side)
//   slave  : the environment (core pipeline and memory system)
interface sram_like_bridge_if;
    import sram_like_bridge_pkg::*;

    // core request / response side
    logic              req_valid;
    logic              req_allowin;
    logic [STRB_W-1:0] req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_allowin;
    logic [DATA_W-1:0] resp_rdata;
    logic              cancel;

    // sram-like bus side
    logic              bus_req;
    logic              bus_wr;
    logic [SIZE_W-1:0] bus_size;
    logic [STRB_W-1:0] bus_wstrb;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, resp_allowin, cancel,
               bus_addr_ok, bus_data_ok, bus_rdata,
        output req_allowin, resp_valid, resp_rdata,
               bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, resp_allowin, cancel,
               bus_addr_ok, bus_data_ok, bus_rdata,
        input  req_allowin, resp_valid, resp_rdata,
               bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata
    );

endinterface

// File: rtl/sram_like_bridge_resp_fifo.sv
// In-order response buffer, first-word fall-through.
//   clk, rst       : clock, async active-high reset
//   i_push/i_wdata : write one entry
//   i_pop          : drop the head entry
//   i_flush        : empty the buffer (wins over push/pop)
//   o_rdata        : head entry
//   o_empty/o_full : occupancy flags
//   o_count        : number of stored entries
module sram_like_bridge_resp_fifo #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointers wrap modulo DEPTH, which need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Storage carries no reset; validity is tracked by r_count
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (i_pop && !i_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;

endmodule

// File: rtl/sram_like_bridge.sv
// Core memory port -> sram-like bus bridge with in-order response buffering
// and branch-cancel support. One instance per core port.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bif  : core request/response and sram-like bus signals (master view)
module sram_like_bridge
    import sram_like_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    sram_like_bridge_if.master bif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    bus_req_t          r_req;
    logic              r_bus_wr;
    logic [SIZE_W-1:0] r_bus_size;
    logic [CNT_W-1:0]  r_inflight;
    logic [CNT_W-1:0]  r_discard;
    logic [CNT_W-1:0]  w_inflight_nxt;
    logic [CNT_W-1:0]  w_discard_nxt;

    logic              w_allowin;
    logic              w_accept;
    logic              w_addr_ok;
    logic              w_req_pending;
    logic [CNT_W:0]    w_occupancy;
    logic [CNT_W:0]    w_cancel_discard;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_fifo_rdata;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [CNT_W-1:0]  w_fifo_count;

    // Every issued-but-undelivered request reserves a buffer slot
    assign w_occupancy = (CNT_W+1)'(r_inflight) + (CNT_W+1)'(w_fifo_count);
    assign w_allowin   = (r_state == ST_IDLE) && !bif.cancel
                         && (w_occupancy < (CNT_W+1)'(DEPTH));
    assign w_accept    = bif.req_valid && w_allowin;
    assign w_addr_ok   = bif.bus_addr_ok && (r_state == ST_REQ);

    // A request counts toward a cancel while on the bus or completing now
    assign w_req_pending = (r_state == ST_REQ) || w_addr_ok;

    assign w_push = bif.bus_data_ok && !bif.cancel && (r_discard == '0);
    assign w_pop  = !w_fifo_empty && bif.resp_allowin && !bif.cancel;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_nxt = ST_REQ;
            ST_REQ:  if (w_addr_ok) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request latch; fields stay put on the bus until addr_ok
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req      <= '0;
            r_bus_wr   <= 1'b0;
            r_bus_size <= '0;
        end else if (w_accept) begin
            r_req.addr  <= bif.req_addr;
            r_req.wdata <= bif.req_wdata;
            r_req.wstrb <= bif.req_we;
            r_bus_wr    <= |bif.req_we;
            r_bus_size  <= wstrb_to_size(bif.req_we);
        end
    end

    // Outstanding and to-be-dropped response counters
    always_comb begin
        w_inflight_nxt = r_inflight + CNT_W'(w_addr_ok) - CNT_W'(bif.bus_data_ok);

        // Already-discarded responses are still inside r_inflight, so a cancel
        // sets the count absolutely rather than adding; repeated cancels
        // cannot double count.
        w_cancel_discard = (CNT_W+1)'(r_inflight) + (CNT_W+1)'(w_req_pending)
                         - (CNT_W+1)'(bif.bus_data_ok);

        w_discard_nxt = r_discard;
        if (bif.cancel) begin
            w_discard_nxt = CNT_W'(w_cancel_discard);
        end else if (bif.bus_data_ok && (r_discard != '0)) begin
            w_discard_nxt = r_discard - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
            r_discard  <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_discard  <= w_discard_nxt;
        end
    end

    sram_like_bridge_resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bif.cancel),
        .i_wdata (bif.bus_rdata),
        .o_rdata (w_fifo_rdata),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    // Slot reservation at accept time makes a push into a full buffer impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && w_fifo_full))
        else $error("response buffer overflow");

    assign bif.req_allowin = w_allowin;
    assign bif.resp_valid  = !w_fifo_empty;
    assign bif.resp_rdata  = w_fifo_rdata;
    assign bif.bus_req     = (r_state == ST_REQ);
    assign bif.bus_wr      = r_bus_wr;
    assign bif.bus_size    = r_bus_size;
    assign bif.bus_wstrb   = r_req.wstrb;
    assign bif.bus_addr    = r_req.addr;
    assign bif.bus_wdata   = r_req.wdata;

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge: a DEPTH=2 and a DEPTH=3 instance share
// the stimulus; each is held in reset while the other one is exercised.
module tb_sram_like_bridge;
    import sram_like_bridge_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst2;
    logic        rst3;
    logic        t_req_valid;
    logic [3:0]  t_req_we;
    logic [31:0] t_req_addr;
    logic [31:0] t_req_wdata;
    logic        t_resp_allowin;
    logic        t_cancel;
    logic        t_addr_ok;
    logic        t_data_ok;
    logic [31:0] t_rdata;

    sram_like_bridge_if bif2 ();
    sram_like_bridge_if bif3 ();

    assign bif2.req_valid    = t_req_valid;
    assign bif2.req_we       = t_req_we;
    assign bif2.req_addr     = t_req_addr;
    assign bif2.req_wdata    = t_req_wdata;
    assign bif2.resp_allowin = t_resp_allowin;
    assign bif2.cancel       = t_cancel;
    assign bif2.bus_addr_ok  = t_addr_ok;
    assign bif2.bus_data_ok  = t_data_ok;
    assign bif2.bus_rdata    = t_rdata;

    assign bif3.req_valid    = t_req_valid;
    assign bif3.req_we       = t_req_we;
    assign bif3.req_addr     = t_req_addr;
    assign bif3.req_wdata    = t_req_wdata;
    assign bif3.resp_allowin = t_resp_allowin;
    assign bif3.cancel       = t_cancel;
    assign bif3.bus_addr_ok  = t_addr_ok;
    assign bif3.bus_data_ok  = t_data_ok;
    assign bif3.bus_rdata    = t_rdata;

    sram_like_bridge #(.DEPTH(2)) dut2 (.clk(clk), .rst(rst2), .bif(bif2));
    sram_like_bridge #(.DEPTH(3)) dut3 (.clk(clk), .rst(rst3), .bif(bif3));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request presentation (caller makes sure allowin is high)
    task automatic issue(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
        t_req_valid = 1'b1;
        t_req_we    = we;
        t_req_addr  = addr;
        t_req_wdata = wdata;
        step();
        t_req_valid = 1'b0;
        t_req_we    = 4'b0;
        #1;
    endtask

    task automatic aok();
        t_addr_ok = 1'b1;
        step();
        t_addr_ok = 1'b0;
        #1;
    endtask

    task automatic dok(input logic [31:0] rdata);
        t_data_ok = 1'b1;
        t_rdata   = rdata;
        step();
        t_data_ok = 1'b0;
        #1;
    endtask

    task automatic pop();
        t_resp_allowin = 1'b1;
        step();
        t_resp_allowin = 1'b0;
        #1;
    endtask

    initial begin
        t_req_valid    = 1'b0;
        t_req_we       = 4'b0;
        t_req_addr     = 32'h0;
        t_req_wdata    = 32'h0;
        t_resp_allowin = 1'b0;
        t_cancel       = 1'b0;
        t_addr_ok      = 1'b0;
        t_data_ok      = 1'b0;
        t_rdata        = 32'h0;
        rst2           = 1'b1;
        rst3           = 1'b1;
        #1;

        // reset state
        chk("rst_bus_req",    32'(bif2.bus_req),    32'd0);
        chk("rst_resp_valid", 32'(bif2.resp_valid), 32'd0);
        chk("rst_bus_addr",   bif2.bus_addr,        32'd0);
        chk("rst_bus_size",   32'(bif2.bus_size),   32'd0);
        chk("rst_bus_wr",     32'(bif2.bus_wr),     32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst2 = 1'b0;
        #1;
        chk("idle_allowin",   32'(bif2.req_allowin), 32'd1);
        chk("idle_inflight",  32'(dut2.r_inflight),  32'd0);

        // word read, addr_ok after two REQ cycles, data_ok one cycle later
        issue(4'b0000, 32'h1c00_0000, 32'h0);
        chk("rd_bus_req",     32'(bif2.bus_req),     32'd1);
        chk("rd_bus_addr",    bif2.bus_addr,         32'h1c00_0000);
        chk("rd_bus_size",    32'(bif2.bus_size),    32'd2);
        chk("rd_bus_wr",      32'(bif2.bus_wr),      32'd0);
        chk("rd_allowin_req", 32'(bif2.req_allowin), 32'd0);
        step();
        chk("rd_req_hold",    32'(bif2.bus_req),     32'd1);
        chk("rd_addr_hold",   bif2.bus_addr,         32'h1c00_0000);
        aok();
        chk("rd_req_drop",    32'(bif2.bus_req),     32'd0);
        chk("rd_inflight1",   32'(dut2.r_inflight),  32'd1);
        dok(32'hdead_beef);
        chk("rd_resp_valid",  32'(bif2.resp_valid),  32'd1);
        chk("rd_resp_rdata",  bif2.resp_rdata,       32'hdead_beef);
        chk("rd_inflight0",   32'(dut2.r_inflight),  32'd0);
        pop();
        chk("rd_popped",      32'(bif2.resp_valid),  32'd0);

        // byte store
        issue(4'b0100, 32'h0000_0002, 32'h00ab_0000);
        chk("sb_bus_wr",      32'(bif2.bus_wr),      32'd1);
        chk("sb_bus_size",    32'(bif2.bus_size),    32'd0);
        chk("sb_bus_wstrb",   32'(bif2.bus_wstrb),   32'h4);
        chk("sb_bus_wdata",   bif2.bus_wdata,        32'h00ab_0000);
        aok();
        dok(32'h0);
        chk("sb_resp_valid",  32'(bif2.resp_valid),  32'd1);
        pop();
        chk("sb_popped",      32'(bif2.resp_valid),  32'd0);

        // upper halfword store
        issue(4'b1100, 32'h0000_0006, 32'h1234_0000);
        chk("sh_bus_size",    32'(bif2.bus_size),    32'd1);
        chk("sh_bus_wr",      32'(bif2.bus_wr),      32'd1);
        aok();
        dok(32'h0);
        pop();
        chk("sh_popped",      32'(bif2.resp_valid),  32'd0);

        // DEPTH=2 backpressure: third read waits for a pop
        issue(4'b0000, 32'h0000_0100, 32'h0);
        aok();
        issue(4'b0000, 32'h0000_0104, 32'h0);
        aok();
        chk("bp_inflight2",   32'(dut2.r_inflight),  32'd2);
        t_req_valid = 1'b1;
        t_req_addr  = 32'h0000_0108;
        #1;
        chk("bp_stall0",      32'(bif2.req_allowin), 32'd0);
        dok(32'h1111_1111);
        chk("bp_stall1",      32'(bif2.req_allowin), 32'd0);
        chk("bp_no_req1",     32'(bif2.bus_req),     32'd0);
        dok(32'h2222_2222);
        chk("bp_stall2",      32'(bif2.req_allowin), 32'd0);
        chk("bp_head_a",      bif2.resp_rdata,       32'h1111_1111);
        pop();
        chk("bp_allowin",     32'(bif2.req_allowin), 32'd1);
        chk("bp_head_b",      bif2.resp_rdata,       32'h2222_2222);
        step();
        t_req_valid = 1'b0;
        #1;
        chk("bp_c_req",       32'(bif2.bus_req),     32'd1);
        chk("bp_c_addr",      bif2.bus_addr,         32'h0000_0108);
        aok();
        dok(32'h3333_3333);
        chk("bp_head_b2",     bif2.resp_rdata,       32'h2222_2222);
        pop();
        chk("bp_head_c",      bif2.resp_rdata,       32'h3333_3333);
        pop();
        chk("bp_empty",       32'(bif2.resp_valid),  32'd0);

        // cancel with two in flight and one buffered (DEPTH=3 instance)
        rst2 = 1'b1;
        rst3 = 1'b0;
        step();
        issue(4'b0000, 32'h0000_0200, 32'h0);
        aok();
        issue(4'b0000, 32'h0000_0204, 32'h0);
        aok();
        chk("cx_allowin3",    32'(bif3.req_allowin), 32'd1);
        issue(4'b0000, 32'h0000_0208, 32'h0);
        aok();
        chk("cx_inflight3",   32'(dut3.r_inflight),  32'd3);
        dok(32'haaaa_aaaa);
        chk("cx_buffered",    32'(bif3.resp_valid),  32'd1);
        t_cancel = 1'b1;
        #1;
        chk("cx_allowin_cx",  32'(bif3.req_allowin), 32'd0);
        step();
        t_cancel = 1'b0;
        #1;
        chk("cx_flushed",     32'(bif3.resp_valid),  32'd0);
        chk("cx_discard2",    32'(dut3.r_discard),   32'd2);
        dok(32'hbbbb_bbbb);
        chk("cx_drop1",       32'(bif3.resp_valid),  32'd0);
        chk("cx_discard1",    32'(dut3.r_discard),   32'd1);
        dok(32'hcccc_cccc);
        chk("cx_drop2",       32'(bif3.resp_valid),  32'd0);
        chk("cx_discard0",    32'(dut3.r_discard),   32'd0);
        chk("cx_inflight0",   32'(dut3.r_inflight),  32'd0);
        issue(4'b0000, 32'h0000_040c, 32'h0);
        aok();
        dok(32'hdddd_dddd);
        chk("cx_new_valid",   32'(bif3.resp_valid),  32'd1);
        chk("cx_new_rdata",   bif3.resp_rdata,       32'hdddd_dddd);
        pop();
        chk("cx_new_popped",  32'(bif3.resp_valid),  32'd0);

        // cancel during REQ with addr_ok in the same cycle (DEPTH=2 instance)
        rst3 = 1'b1;
        rst2 = 1'b0;
        step();
        issue(4'b0000, 32'h0000_0500, 32'h0);
        t_cancel  = 1'b1;
        t_addr_ok = 1'b1;
        step();
        t_cancel  = 1'b0;
        t_addr_ok = 1'b0;
        #1;
        chk("cr_bus_req",     32'(bif2.bus_req),     32'd0);
        chk("cr_discard1",    32'(dut2.r_discard),   32'd1);
        chk("cr_inflight1",   32'(dut2.r_inflight),  32'd1);
        dok(32'heeee_eeee);
        chk("cr_dropped",     32'(bif2.resp_valid),  32'd0);
        chk("cr_discard0",    32'(dut2.r_discard),   32'd0);
        chk("cr_inflight0",   32'(dut2.r_inflight),  32'd0);

        // asynchronous reset while a request is on the bus
        issue(4'b0000, 32'h0000_0600, 32'h0);
        aok();
        dok(32'h6666_6666);
        issue(4'b0000, 32'h0000_0604, 32'h0);
        chk("ar_bus_req_pre", 32'(bif2.bus_req),     32'd1);
        chk("ar_valid_pre",   32'(bif2.resp_valid),  32'd1);
        rst2 = 1'b1;
        #1;
        chk("ar_bus_req",     32'(bif2.bus_req),     32'd0);
        chk("ar_resp_valid",  32'(bif2.resp_valid),  32'd0);
        chk("ar_bus_addr",    bif2.bus_addr,         32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
